// File: rtl/mire.sv
// Revision constant for the mire file set; the top lives in mire_wshb.sv.
package mire_files_pkg;
  localparam int MIRE_REV = 1;
endpackage

// File: rtl/mire_pkg.sv
// Shared types and constants for the mire (test pattern) Wishbone writer.
package mire_pkg;

  typedef enum logic [0:0] {
    PAUSE = 1'b0,
    WRITE = 1'b1
  } state_t;

  // RGB565 colours used by the patterns
  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] MAGENTA = 16'hF81F;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] BLACK   = 16'h0000;

  // Pattern codes as presented on pattern_sel
  localparam logic [1:0] PAT_GRID  = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_GRAD  = 2'd3;

  // Colour of a vertical bar; any index past the last bar stays black,
  // which gives the saturation at bar 7 for free.
  function automatic logic [15:0] bar_colour(input logic [15:0] idx);
    logic [15:0] c;
    case (idx)
      16'd0:   c = WHITE;
      16'd1:   c = YELLOW;
      16'd2:   c = CYAN;
      16'd3:   c = GREEN;
      16'd4:   c = MAGENTA;
      16'd5:   c = RED;
      16'd6:   c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mire_wshb_if.sv
// 16-bit Wishbone classic bus between the mire writer and the interconnect.
interface wshb_if;
  logic [31:0] adr;
  logic [15:0] dat_ms;
  logic [1:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (output adr, dat_ms, sel, we, cyc, stb, cti, bte, input ack);
  modport slave  (input adr, dat_ms, sel, we, cyc, stb, cti, bte, output ack);
endinterface

// File: rtl/mire_pattern.sv
// Combinational pixel generator: (x, y, pattern) -> RGB565 colour.
module mire_pattern
  import mire_pkg::*;
#(
  parameter int HDISP = 640,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [1:0]    pat,
  output logic [15:0]   pixel
);

  // Bars are HDISP/8 wide; guard tiny screens against a zero width.
  localparam int BAR_W = ((HDISP / 8) > 0) ? (HDISP / 8) : 1;

  logic [15:0] xe;
  logic [15:0] ye;
  logic [15:0] bar;
  logic [4:0]  g5;
  logic [5:0]  g6;

  // Select the colour of the current pixel for the active pattern
  always_comb begin
    xe    = 16'(x);
    ye    = 16'(y);
    bar   = xe / 16'(BAR_W);
    g5    = 5'((xe >> 5) & 16'h001F);
    g6    = 6'((xe >> 4) & 16'h003F);
    pixel = BLACK;
    case (pat)
      PAT_GRID: begin
        if (((xe & 16'h000F) == 16'h0000) || ((ye & 16'h000F) == 16'h0000)) begin
          pixel = WHITE;
        end else begin
          pixel = BLACK;
        end
      end
      PAT_BARS: pixel = bar_colour(bar);
      PAT_CHECK: begin
        if (((xe ^ ye) & 16'h0020) != 16'h0000) begin
          pixel = WHITE;
        end else begin
          pixel = BLACK;
        end
      end
      PAT_GRAD: pixel = {g5, g6, g5};
      default:  pixel = BLACK;
    endcase
  end

endmodule

// File: rtl/mire_wshb.sv
// Wishbone master that paints a test pattern into the framebuffer in raster
// order, one RGB565 pixel per write, releasing the bus every BURST writes.
module mire_wshb
  import mire_pkg::*;
#(
  parameter int HDISP = 640,
  parameter int VDISP = 480,
  parameter int BURST = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic [1:0] pattern_sel,
  wshb_if.master     wshb_ifm,
  output logic       frame_done
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  state_t        state;
  state_t        state_next;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [BW-1:0] burst_cnt;
  logic [1:0]    pat;

  logic          take;
  logic          last_x;
  logic          last_px;
  logic          burst_end;
  logic          leave;
  logic [31:0]   pix_idx;
  logic [15:0]   pixel;

  // Decode the events that drive counters and the state machine
  always_comb begin
    take      = (state == WRITE) && wshb_ifm.ack;
    last_x    = (x == XW'(HDISP - 1));
    last_px   = last_x && (y == YW'(VDISP - 1));
    burst_end = (burst_cnt == BW'(BURST - 1));
    leave     = burst_end || !en || last_px;
  end

  // Next-state logic: a transfer only ends on ack, then the bus is released
  // if the burst is used up, the enable dropped or the frame finished.
  always_comb begin
    state_next = state;
    case (state)
      PAUSE: begin
        if (en) begin
          state_next = WRITE;
        end else begin
          state_next = PAUSE;
        end
      end
      WRITE: begin
        if (take && leave) begin
          state_next = PAUSE;
        end else begin
          state_next = WRITE;
        end
      end
      default: state_next = PAUSE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= PAUSE;
    end else begin
      state <= state_next;
    end
  end

  // Raster position and burst counter advance once per accepted write
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x         <= '0;
      y         <= '0;
      burst_cnt <= '0;
    end else if (take) begin
      if (last_x) begin
        x <= '0;
        if (y == YW'(VDISP - 1)) begin
          y <= '0;
        end else begin
          y <= y + YW'(1);
        end
      end else begin
        x <= x + XW'(1);
      end
      if (leave) begin
        burst_cnt <= '0;
      end else begin
        burst_cnt <= burst_cnt + BW'(1);
      end
    end else begin
      x         <= x;
      y         <= y;
      burst_cnt <= burst_cnt;
    end
  end

  // Pattern latched only at frame boundaries so a frame is never mixed
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pat <= PAT_GRID;
    end else if (take && last_px) begin
      pat <= pattern_sel;
    end else if ((state == PAUSE) && (x == '0) && (y == '0)) begin
      pat <= pattern_sel;
    end else begin
      pat <= pat;
    end
  end

  // One-cycle pulse following the ack of the last pixel
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= take && last_px;
    end
  end

  mire_pattern #(
    .HDISP (HDISP),
    .XW    (XW),
    .YW    (YW)
  ) u_pattern (
    .x     (x),
    .y     (y),
    .pat   (pat),
    .pixel (pixel)
  );

  // Byte address of the current pixel: two bytes per pixel
  assign pix_idx         = 32'(y) * 32'(HDISP) + 32'(x);
  assign wshb_ifm.adr    = pix_idx << 1;
  assign wshb_ifm.dat_ms = pixel;
  assign wshb_ifm.cyc    = (state == WRITE);
  assign wshb_ifm.stb    = (state == WRITE);
  assign wshb_ifm.we     = 1'b1;
  assign wshb_ifm.sel    = 2'b11;
  assign wshb_ifm.cti    = 3'b000;
  assign wshb_ifm.bte    = 2'b00;

endmodule
